// File: rtl/inpr_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inpr_buffer_pkg                                            |
// | Description : Shared CPU constants used by the INPR input buffer:        |
// |               datapath word width, INPR buffer depth and the word type.  |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package inpr_buffer_pkg;

  // CPU datapath word width.
  localparam int DATA_W = 18;

  // Depth of the INPR input FIFO, in words (power of two, at least 2).
  localparam int INPR_DEPTH = 4;

  typedef logic [DATA_W-1:0] word_t;

endpackage : inpr_buffer_pkg
`default_nettype wire

// File: rtl/inpr_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inpr_buffer_if                                             |
// | Description : Bundle of the device-side handshake and the CPU-side INPR  |
// |               signals of the input buffer.                               |
// | Modports    : slave  - the buffer (accepts device words, serves CPU)     |
// |               master - device + CPU control side driving the buffer      |
// | Signals     : dev_data/dev_valid/dev_ready  device push handshake        |
// |               inpr_read_en/inpr_data/i_flag CPU pop strobe, head, flag   |
// |               count, underflow, clr_err     occupancy and error status   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface inpr_buffer_if
  import inpr_buffer_pkg::*;
#(
  parameter int DEPTH = INPR_DEPTH
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  word_t            dev_data;
  logic             dev_valid;
  logic             dev_ready;
  logic             inpr_read_en;
  word_t            inpr_data;
  logic             i_flag;
  logic [CNT_W-1:0] count;
  logic             underflow;
  logic             clr_err;

  modport slave (
    input  dev_data,
    input  dev_valid,
    output dev_ready,
    input  inpr_read_en,
    output inpr_data,
    output i_flag,
    output count,
    output underflow,
    input  clr_err
  );

  modport master (
    output dev_data,
    output dev_valid,
    input  dev_ready,
    output inpr_read_en,
    input  inpr_data,
    input  i_flag,
    input  count,
    input  underflow,
    output clr_err
  );

endinterface : inpr_buffer_if
`default_nettype wire

// File: rtl/inpr_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inpr_fifo_mem                                              |
// | Description : DEPTH x DATA_W register array, one synchronous write port  |
// |               and one asynchronous read port.                            |
// | Ports       : clk      in   write clock                                  |
// |               wr_en    in   write strobe                                 |
// |               wr_addr  in   write address                                |
// |               wr_data  in   write data                                   |
// |               rd_addr  in   read address                                 |
// |               rd_data  out  array[rd_addr], combinational                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module inpr_fifo_mem #(
  parameter  int DATA_W = 18,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              wr_en,
  input  wire logic [PTR_W-1:0]  wr_addr,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic [PTR_W-1:0]  rd_addr,
  output logic      [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; the read side masks stale
  // contents through the occupancy count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == PTR_W'(i))) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : inpr_fifo_mem
`default_nettype wire

// File: rtl/inpr_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : inpr_buffer                                                |
// | Description : First-word-fall-through input FIFO feeding the CPU INPR    |
// |               path. Device words are pushed over valid/ready; the CPU    |
// |               sees the head word plus an input-ready flag and pops with  |
// |               inpr_read_en. Pops while empty set a sticky underflow.     |
// | Ports       : clk   in  system clock (rising edge)                       |
// |               rst   in  synchronous active-high reset                    |
// |               bus   slave modport of inpr_buffer_if                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module inpr_buffer
  import inpr_buffer_pkg::*;
#(
  parameter int DEPTH = INPR_DEPTH
) (
  input wire logic    clk,
  input wire logic    rst,
  inpr_buffer_if.slave bus
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;

  logic  empty;
  logic  full;
  logic  push;
  logic  pop;
  logic  pop_empty;
  word_t head_word;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Ready depends only on registered occupancy and rst, so a pop in the
  // same cycle never frees a slot for a concurrent push.
  assign bus.dev_ready = !rst && !full;

  // dev_ready is already low during reset, so push cannot write memory then.
  assign push      = bus.dev_valid && bus.dev_ready;
  assign pop       = bus.inpr_read_en && !empty;
  assign pop_empty = bus.inpr_read_en && empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (rst) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase

      // Set has priority over clear.
      if (pop_empty) begin
        underflow_d = 1'b1;
      end else if (bus.clr_err) begin
        underflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    underflow_q <= underflow_d;
  end

  inpr_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.dev_data),
    .rd_addr (rd_ptr_q),
    .rd_data (head_word)
  );

  // Fall-through head; forced to zero when empty so stale words never leak.
  assign bus.inpr_data = empty ? '0 : head_word;
  assign bus.i_flag    = !empty;
  assign bus.count     = count_q;
  assign bus.underflow = underflow_q;

endmodule : inpr_buffer
`default_nettype wire

// File: tb/tb_inpr_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_inpr_buffer                                             |
// | Description : Self-checking bench for inpr_buffer: directed vector table,|
// |               hand-written corner sequences and random traffic compared  |
// |               against a queue-based reference model.                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_inpr_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inpr_buffer_if #(.DEPTH(DEPTH)) bus ();

  inpr_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the buffer contents as a plain queue.
  logic [17:0] mq[$];
  logic        uf_m = 1'b0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [17:0] data;
    logic        rd;
    logic        clr;
    int          cnt;
    logic [17:0] dout;
    logic        iflag;
    logic        rdy;
    logic        uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic [17:0] d, logic rd_i, logic c,
                              int cnt, logic [17:0] dout, logic fl, logic rdy, logic uf);
    vec_t x;
    x.rst = r; x.vld = v; x.data = d; x.rd = rd_i; x.clr = c;
    x.cnt = cnt; x.dout = dout; x.iflag = fl; x.rdy = rdy; x.uf = uf;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [17:0] d,
                            input logic rd_i, input logic c);
    int sz;
    logic do_push, do_pop;
    if (r) begin
      mq.delete();
      uf_m = 1'b0;
    end else begin
      sz      = mq.size();
      do_push = v && (sz != DEPTH);
      do_pop  = rd_i && (sz != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      if (rd_i && sz == 0) uf_m = 1'b1;
      else if (c)          uf_m = 1'b0;
    end
  endtask

  task automatic check_model();
    logic [17:0] exp_d;
    exp_d = (mq.size() != 0) ? mq[0] : 18'h0;
    chk("m_count", 32'(bus.count), mq.size());
    chk("m_data", 32'(bus.inpr_data), 32'(exp_d));
    chk("m_iflag", 32'(bus.i_flag), 32'(mq.size() != 0));
    chk("m_ready", 32'(bus.dev_ready), 32'(!rst && mq.size() != DEPTH));
    chk("m_uf", 32'(bus.underflow), 32'(uf_m));
  endtask

  // One clock: drive inputs, check ready before the edge, step model, check after.
  task automatic cycle(input logic r, input logic v, input logic [17:0] d,
                       input logic rd_i, input logic c);
    rst = r; bus.dev_valid = v; bus.dev_data = d; bus.inpr_read_en = rd_i; bus.clr_err = c;
    #1;
    chk("ready_pre", 32'(bus.dev_ready), 32'(!r && mq.size() != DEPTH));
    @(posedge clk);
    model_step(r, v, d, rd_i, c);
    #1;
    check_model();
  endtask

  initial begin
    bus.dev_valid = 1'b0; bus.dev_data = '0; bus.inpr_read_en = 1'b0; bus.clr_err = 1'b0;

    // ---------------- directed vector table ----------------
    //               rst vld data      rd clr  cnt dout      fl rdy uf
    vecs.push_back(mk(1, 0, 18'h00000, 0, 0,  0, 18'h00000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 18'h00001, 0, 0,  1, 18'h00001, 1, 1, 0));
    vecs.push_back(mk(0, 1, 18'h2ABCD, 0, 0,  2, 18'h00001, 1, 1, 0));
    vecs.push_back(mk(0, 1, 18'h3FFFF, 0, 0,  3, 18'h00001, 1, 1, 0));
    vecs.push_back(mk(0, 1, 18'h00000, 0, 0,  4, 18'h00001, 1, 0, 0));
    vecs.push_back(mk(0, 1, 18'h12345, 0, 0,  4, 18'h00001, 1, 0, 0));
    vecs.push_back(mk(0, 0, 18'h00000, 1, 0,  3, 18'h2ABCD, 1, 1, 0));
    vecs.push_back(mk(0, 0, 18'h00000, 1, 0,  2, 18'h3FFFF, 1, 1, 0));
    vecs.push_back(mk(0, 0, 18'h00000, 1, 0,  1, 18'h00000, 1, 1, 0));
    vecs.push_back(mk(0, 0, 18'h00000, 1, 0,  0, 18'h00000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 18'h00000, 1, 0,  0, 18'h00000, 0, 1, 1));
    vecs.push_back(mk(0, 0, 18'h00000, 0, 0,  0, 18'h00000, 0, 1, 1));
    vecs.push_back(mk(0, 0, 18'h00000, 0, 1,  0, 18'h00000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 18'h00000, 1, 1,  0, 18'h00000, 0, 1, 1));
    vecs.push_back(mk(0, 0, 18'h00000, 0, 1,  0, 18'h00000, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].rd, vecs[i].clr);
      chk($sformatf("v%0d_count", i), 32'(bus.count), vecs[i].cnt);
      chk($sformatf("v%0d_data", i), 32'(bus.inpr_data), 32'(vecs[i].dout));
      chk($sformatf("v%0d_iflag", i), 32'(bus.i_flag), 32'(vecs[i].iflag));
      chk($sformatf("v%0d_ready", i), 32'(bus.dev_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_uf", i), 32'(bus.underflow), 32'(vecs[i].uf));
    end

    // ---------------- streaming at count = 2 across pointer wrap ----------------
    cycle(0, 1, 18'h000AA, 0, 0);
    cycle(0, 1, 18'h000BB, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 18'(18'h100 + i), 1, 0);
      chk("stream_count", 32'(bus.count), 2);
      chk("stream_head", 32'(bus.inpr_data), (i == 0) ? 32'h0BB : 32'(18'h100 + i - 1));
      chk("stream_uf", 32'(bus.underflow), 0);
    end
    cycle(0, 0, 18'h0, 1, 0);
    chk("stream_tail", 32'(bus.inpr_data), 32'h109);
    cycle(0, 0, 18'h0, 1, 0);

    // ---------------- full buffer with simultaneous push and pop ----------------
    for (int i = 1; i <= 4; i++) cycle(0, 1, 18'(18'h200 + i), 0, 0);
    cycle(0, 1, 18'h2AA, 1, 0);
    chk("full_pp_count", 32'(bus.count), 3);
    chk("full_pp_head", 32'(bus.inpr_data), 32'h202);
    cycle(0, 1, 18'h2AA, 0, 0);
    chk("full_retry_count", 32'(bus.count), 4);
    for (int i = 0; i < 3; i++) cycle(0, 0, 18'h0, 1, 0);
    chk("full_retry_word", 32'(bus.inpr_data), 32'h2AA);
    cycle(0, 0, 18'h0, 1, 0);

    // ---------------- reset mid-transfer ----------------
    for (int i = 1; i <= 3; i++) cycle(0, 1, 18'(18'h300 + i), 0, 0);
    rst = 1'b1; bus.dev_valid = 1'b1; bus.dev_data = 18'h377;
    #1;
    chk("rst_ready_low", 32'(bus.dev_ready), 0);
    cycle(1, 1, 18'h377, 0, 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_iflag", 32'(bus.i_flag), 0);
    rst = 1'b0; bus.dev_valid = 1'b0;
    #1;
    chk("rst_ready_high", 32'(bus.dev_ready), 1);
    cycle(0, 0, 18'h0, 0, 0);
    chk("rst_no_store", 32'(bus.count), 0);
    chk("rst_data_zero", 32'(bus.inpr_data), 0);

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 39) == 0,
            $urandom_range(0, 2) != 0,
            18'($urandom),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_inpr_buffer
`default_nettype wire
